// File: rtl/sdram_word_port.sv
// sdram_word_port: splits 32-bit CPU word reads/writes into two halfword
// requests for a native 16-bit SDRAM controller. The low halfword lives at
// {word_addr, 1'b0}, the high halfword at {word_addr, 1'b1}.
//
// Handshakes:
//   CPU side : sdram_rd / sdram_wr are single-cycle pulses sampled only while
//              idle; sdram_busy covers the whole transaction and read data is
//              marked by a one-cycle sdram_rdata_valid pulse.
//   PHY side : phy_req is held with phy_we/phy_addr/phy_wdata stable until a
//              one-cycle phy_ack; read halfwords come back later, in request
//              order, each marked by a one-cycle phy_rdata_valid pulse.
// A stalled transaction is aborted after TIMEOUT_CYCLES quiet cycles.
// o_dbg_state exposes the FSM state for observation.
module sdram_word_port #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sdram_rd,
  input  logic        sdram_wr,
  input  logic [23:0] sdram_addr,
  input  logic [31:0] sdram_wdata,
  output logic [31:0] sdram_rdata,
  output logic        sdram_busy,
  output logic        sdram_rdata_valid,
  output logic        phy_req,
  output logic        phy_we,
  output logic [24:0] phy_addr,
  output logic [15:0] phy_wdata,
  input  logic        phy_ack,
  input  logic [15:0] phy_rdata,
  input  logic        phy_rdata_valid,
  output logic        err_timeout,
  output logic [2:0]  o_dbg_state
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_LO   = 3'd1,
    WR_HI   = 3'd2,
    RD_LO   = 3'd3,
    RD_HI   = 3'd4,
    RD_WAIT = 3'd5
  } state_t;

  state_t        r_state;
  logic [23:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_buf;
  logic [1:0]    r_beat;
  logic [TW-1:0] r_tmo;
  logic          r_req;
  logic          r_we;
  logic [24:0]   r_phy_addr;
  logic [15:0]   r_phy_wdata;
  logic          r_busy;
  logic [31:0]   r_rdata;
  logic          r_rvalid;
  logic          r_err;

  state_t        w_state_n;
  logic [23:0]   w_addr_n;
  logic [31:0]   w_wdata_n;
  logic [31:0]   w_buf_n;
  logic [1:0]    w_beat_n;
  logic [TW-1:0] w_tmo_n;
  logic          w_req_n;
  logic          w_we_n;
  logic [24:0]   w_phy_addr_n;
  logic [15:0]   w_phy_wdata_n;
  logic          w_busy_n;
  logic [31:0]   w_rdata_n;
  logic          w_rvalid_n;
  logic          w_err_n;
  logic          w_in_rd;
  logic          w_beat_in;
  logic          w_abort;
  logic          w_last_beat;
  logic [31:0]   w_word;

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    w_state_n     = r_state;
    w_addr_n      = r_addr;
    w_wdata_n     = r_wdata;
    w_buf_n       = r_buf;
    w_beat_n      = r_beat;
    w_req_n       = 1'b0;
    w_we_n        = 1'b0;
    w_phy_addr_n  = r_phy_addr;
    w_phy_wdata_n = r_phy_wdata;
    w_busy_n      = r_busy;
    w_rdata_n     = r_rdata;
    w_rvalid_n    = 1'b0;
    w_err_n       = 1'b0;

    // Read beats only count while a read is outstanding; anything else is stale.
    w_in_rd     = (r_state == RD_LO) || (r_state == RD_HI) || (r_state == RD_WAIT);
    w_beat_in   = w_in_rd && phy_rdata_valid;
    w_abort     = (r_state != IDLE) && (r_tmo == TMO_LAST);
    w_last_beat = (r_beat == 2'd2) || (w_beat_in && (r_beat == 2'd1));
    w_word      = {(w_beat_in && (r_beat == 2'd1)) ? phy_rdata : r_buf[31:16],
                   r_buf[15:0]};

    if (w_beat_in && (r_beat < 2'd2)) begin
      w_beat_n = r_beat + 2'd1;
      if (r_beat == 2'd0) w_buf_n[15:0]  = phy_rdata;
      else                w_buf_n[31:16] = phy_rdata;
    end

    case (r_state)
      IDLE: begin
        if (sdram_wr) begin
          w_state_n     = WR_LO;
          w_addr_n      = sdram_addr;
          w_wdata_n     = sdram_wdata;
          w_req_n       = 1'b1;
          w_we_n        = 1'b1;
          w_phy_addr_n  = {sdram_addr, 1'b0};
          w_phy_wdata_n = sdram_wdata[15:0];
          w_busy_n      = 1'b1;
        end else if (sdram_rd) begin
          w_state_n    = RD_LO;
          w_addr_n     = sdram_addr;
          w_req_n      = 1'b1;
          w_phy_addr_n = {sdram_addr, 1'b0};
          w_busy_n     = 1'b1;
          w_beat_n     = 2'd0;
        end
      end
      WR_LO: begin
        w_req_n = 1'b1;
        w_we_n  = 1'b1;
        if (phy_ack) begin
          w_state_n     = WR_HI;
          w_phy_addr_n  = {r_addr, 1'b1};
          w_phy_wdata_n = r_wdata[31:16];
        end
      end
      WR_HI: begin
        w_req_n = 1'b1;
        w_we_n  = 1'b1;
        if (phy_ack) begin
          w_state_n = IDLE;
          w_req_n   = 1'b0;
          w_we_n    = 1'b0;
          w_busy_n  = 1'b0;
        end
      end
      RD_LO: begin
        w_req_n = 1'b1;
        if (phy_ack) begin
          w_state_n    = RD_HI;
          w_phy_addr_n = {r_addr, 1'b1};
        end
      end
      RD_HI: begin
        w_req_n = 1'b1;
        if (phy_ack) begin
          w_state_n = RD_WAIT;
          w_req_n   = 1'b0;
        end
      end
      RD_WAIT: begin
        if (w_last_beat) begin
          w_state_n  = IDLE;
          w_rdata_n  = w_word;
          w_rvalid_n = 1'b1;
          w_busy_n   = 1'b0;
        end
      end
      default: begin
        w_state_n = IDLE;
        w_busy_n  = 1'b0;
      end
    endcase

    // A stalled transaction is dropped; an aborted read still answers, with zero.
    if (w_abort) begin
      w_state_n = IDLE;
      w_req_n   = 1'b0;
      w_we_n    = 1'b0;
      w_busy_n  = 1'b0;
      w_err_n   = 1'b1;
      if (w_in_rd) begin
        w_rvalid_n = 1'b1;
        w_rdata_n  = 32'h0;
      end
    end

    // Quiet-cycle counter: any progress or state change restarts it.
    if ((w_state_n != r_state) || phy_ack || phy_rdata_valid || (r_state == IDLE))
      w_tmo_n = '0;
    else
      w_tmo_n = r_tmo + TW'(1);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_buf       <= '0;
      r_beat      <= '0;
      r_tmo       <= '0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_phy_addr  <= '0;
      r_phy_wdata <= '0;
      r_busy      <= 1'b0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_addr      <= w_addr_n;
      r_wdata     <= w_wdata_n;
      r_buf       <= w_buf_n;
      r_beat      <= w_beat_n;
      r_tmo       <= w_tmo_n;
      r_req       <= w_req_n;
      r_we        <= w_we_n;
      r_phy_addr  <= w_phy_addr_n;
      r_phy_wdata <= w_phy_wdata_n;
      r_busy      <= w_busy_n;
      r_rdata     <= w_rdata_n;
      r_rvalid    <= w_rvalid_n;
      r_err       <= w_err_n;
    end
  end

  assign sdram_rdata       = r_rdata;
  assign sdram_busy        = r_busy;
  assign sdram_rdata_valid = r_rvalid;
  assign phy_req           = r_req;
  assign phy_we            = r_we;
  assign phy_addr          = r_phy_addr;
  assign phy_wdata         = r_phy_wdata;
  assign err_timeout       = r_err;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_sdram_word_port.sv
// Bench for sdram_word_port: a halfword PHY responder with adjustable ack and
// read latency, a word-level memory reference, and an expected-read queue.
module tb_sdram_word_port;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        sdram_rd;
  logic        sdram_wr;
  logic [23:0] sdram_addr;
  logic [31:0] sdram_wdata;
  logic [31:0] sdram_rdata;
  logic        sdram_busy;
  logic        sdram_rdata_valid;
  logic        phy_req;
  logic        phy_we;
  logic [24:0] phy_addr;
  logic [15:0] phy_wdata;
  logic        phy_ack = 1'b0;
  logic [15:0] phy_rdata = 16'h0;
  logic        phy_rdata_valid = 1'b0;
  logic        err_timeout;
  logic [2:0]  dbg_state;

  int n_vec  = 0;
  int n_miss = 0;

  sdram_word_port #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .sdram_rd(sdram_rd), .sdram_wr(sdram_wr),
    .sdram_addr(sdram_addr), .sdram_wdata(sdram_wdata),
    .sdram_rdata(sdram_rdata), .sdram_busy(sdram_busy),
    .sdram_rdata_valid(sdram_rdata_valid),
    .phy_req(phy_req), .phy_we(phy_we), .phy_addr(phy_addr),
    .phy_wdata(phy_wdata), .phy_ack(phy_ack), .phy_rdata(phy_rdata),
    .phy_rdata_valid(phy_rdata_valid), .err_timeout(err_timeout),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- PHY responder ----------------
  typedef struct {logic [15:0] d; int due;} beat_t;
  typedef struct {logic we; logic [24:0] a; logic [15:0] d;} phy_txn_t;

  logic [15:0] phy_mem [int];
  beat_t       rd_q[$];
  phy_txn_t    log_q[$];
  logic        req_log[$];
  int          ack_lat = 0;   // -1 withholds acks
  int          rd_lat  = 1;
  int          ack_cnt = 0;
  int          cyc     = 0;
  int          beats_sent = 0;
  beat_t       pb;
  phy_txn_t    pt;

  function automatic logic [15:0] phy_rd(input logic [24:0] a);
    return phy_mem.exists(int'(a)) ? phy_mem[int'(a)] : 16'h0;
  endfunction

  // Drive PHY inputs on the falling edge so the DUT samples them at the next rise.
  always @(negedge clk) begin
    cyc++;
    phy_ack = 1'b0;
    phy_rdata_valid = 1'b0;
    if (reset) begin
      rd_q.delete();
      ack_cnt = 0;
    end else begin
      if (phy_req && ack_lat >= 0) begin
        if (ack_cnt >= ack_lat) begin
          phy_ack = 1'b1;
          ack_cnt = 0;
          pt.we = phy_we; pt.a = phy_addr; pt.d = phy_wdata;
          log_q.push_back(pt);
          if (phy_we) phy_mem[int'(phy_addr)] = phy_wdata;
          else begin
            pb.d = phy_rd(phy_addr);
            pb.due = cyc + rd_lat;
            rd_q.push_back(pb);
          end
        end else ack_cnt++;
      end else ack_cnt = 0;
      if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        phy_rdata = rd_q[0].d;
        phy_rdata_valid = 1'b1;
        void'(rd_q.pop_front());
        req_log.push_back(phy_req);
        beats_sent++;
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] ref_mem [int];
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = 32'h0;
  logic        allow_err = 1'b0;

  function automatic logic [31:0] ref_rd(input logic [23:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
  endfunction

  task automatic preload(input logic [23:0] a, input logic [31:0] w);
    ref_mem[int'(a)] = w;
    phy_mem[int'({a, 1'b0})] = w[15:0];
    phy_mem[int'({a, 1'b1})] = w[31:16];
  endtask

  // Every read completion is matched against the oldest expected word.
  always @(negedge clk) begin
    if (!reset && sdram_rdata_valid) begin
      if (exp_q.size() == 0) check("unexpected_rdata_valid", 32'(sdram_rdata_valid), 32'h0);
      else begin
        check("rdata", sdram_rdata, exp_q.pop_front());
        check("busy_at_rdata_valid", 32'(sdram_busy), 32'h0);
      end
    end
    if (!reset && err_timeout) check("err_timeout_allowed", 32'(err_timeout), 32'(allow_err));
  end

  // ---------------- driver tasks ----------------
  // mode 0: normal, 1: read expected to abort (zero), 2: no completion expected
  task automatic issue(input logic rd, input logic wr, input logic [23:0] a,
                       input logic [31:0] d, input int mode);
    @(negedge clk);
    sdram_rd = rd; sdram_wr = wr; sdram_addr = a; sdram_wdata = d;
    if (wr) ref_mem[int'(a)] = d;
    else if (rd) begin
      if (mode == 0) begin last_rd = ref_rd(a); exp_q.push_back(last_rd); end
      else if (mode == 1) begin last_rd = 32'h0; exp_q.push_back(32'h0); end
    end
    @(negedge clk);
    sdram_rd = 1'b0; sdram_wr = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (sdram_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(sdram_busy), 32'h0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   32'(sdram_busy), 32'h0);
    check({tag, "_rvalid"}, 32'(sdram_rdata_valid), 32'h0);
    check({tag, "_req"},    32'(phy_req), 32'h0);
    check({tag, "_we"},     32'(phy_we), 32'h0);
    check({tag, "_err"},    32'(err_timeout), 32'h0);
    check({tag, "_paddr"},  32'(phy_addr), 32'h0);
    check({tag, "_pwdata"}, 32'(phy_wdata), 32'h0);
    check({tag, "_rdata"},  sdram_rdata, 32'h0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    int b0;
    int op;
    logic [23:0] ra;
    logic [31:0] rd_w;
    beat_t sb;

    reset = 1'b1; sdram_rd = 1'b0; sdram_wr = 1'b0;
    sdram_addr = '0; sdram_wdata = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Word write, immediate acks: two halfword writes, busy for 2 cycles.
    log_q.delete();
    ack_lat = 0;
    issue(1'b0, 1'b1, 24'h000010, 32'hCAFEBABE, 0);
    wait_idle("wr_idle", n);
    check("wr_busy_cycles", 32'(n), 32'd2);
    check("wr_log_size", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      check("wr_lo_addr", 32'(log_q[0].a), 32'h20);
      check("wr_lo_data", 32'(log_q[0].d), 32'hBABE);
      check("wr_hi_addr", 32'(log_q[1].a), 32'h21);
      check("wr_hi_data", 32'(log_q[1].d), 32'hCAFE);
      check("wr_we", 32'({log_q[0].we, log_q[1].we}), 32'h3);
    end

    // Word read, latency 4.
    preload(24'h000003, 32'h12345678);
    rd_lat = 4;
    issue(1'b1, 1'b0, 24'h000003, 32'h0, 0);
    wait_idle("rd_idle", n);
    check("rd_done", 32'(exp_q.size()), 32'h0);
    check("rd_word", sdram_rdata, 32'h12345678);

    // rd+wr together: write wins; a read pulse while busy is dropped.
    log_q.delete();
    rd_lat = 1;
    issue(1'b1, 1'b1, 24'h000020, 32'h11112222, 0);
    sdram_rd = 1'b1; sdram_addr = 24'h000005;
    @(negedge clk);
    sdram_rd = 1'b0;
    wait_idle("rdwr_idle", n);
    repeat (5) @(negedge clk);
    check("rdwr_log_size", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) check("rdwr_we", 32'({log_q[0].we, log_q[1].we}), 32'h3);
    check("rdwr_no_read", 32'(exp_q.size()), 32'h0);
    check("rdwr_rdata_hold", sdram_rdata, last_rd);

    // Read with acks withheld: abort after TMO quiet cycles.
    ack_lat = -1;
    allow_err = 1'b1;
    issue(1'b1, 1'b0, 24'h000007, 32'h0, 1);
    n = 0;
    while (!err_timeout && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", 32'(n), 32'(TMO));
    check("tmo_rvalid", 32'(sdram_rdata_valid), 32'h1);
    check("tmo_rdata", sdram_rdata, 32'h0);
    check("tmo_busy", 32'(sdram_busy), 32'h0);
    check("tmo_req", 32'(phy_req), 32'h0);
    @(negedge clk);
    allow_err = 1'b0;
    ack_lat = 0;
    sb.d = 16'hDEAD; sb.due = cyc;
    rd_q.push_back(sb);
    repeat (6) @(negedge clk);
    check("stale_busy", 32'(sdram_busy), 32'h0);
    check("stale_rdata", sdram_rdata, 32'h0);
    check("stale_no_rvalid", 32'(exp_q.size()), 32'h0);

    // Reset in RD_WAIT after one beat; a write pulse during reset is ignored.
    preload(24'h000009, 32'hA5A55A5A);
    rd_lat = 4;
    b0 = beats_sent;
    issue(1'b1, 1'b0, 24'h000009, 32'h0, 2);
    n = 0;
    while (beats_sent <= b0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("mid_rst_busy_before", 32'(sdram_busy), 32'h1);
    reset = 1'b1; sdram_wr = 1'b1; sdram_addr = 24'h000011; sdram_wdata = 32'h99998888;
    repeat (2) @(negedge clk);
    check_reset_outputs("mid_rst");
    reset = 1'b0; sdram_wr = 1'b0;
    last_rd = 32'h0;
    @(negedge clk);
    check("rst_prio_busy", 32'(sdram_busy), 32'h0);
    check("rst_prio_req", 32'(phy_req), 32'h0);
    rd_lat = 2;
    issue(1'b1, 1'b0, 24'h000009, 32'h0, 0);
    wait_idle("post_rst_idle", n);
    check("post_rst_read", sdram_rdata, 32'hA5A55A5A);

    // First beat arrives before the high request is acknowledged.
    preload(24'h00000C, 32'hDEADBEEF);
    ack_lat = 4;
    rd_lat = 1;
    b0 = beats_sent;
    issue(1'b1, 1'b0, 24'h00000C, 32'h0, 0);
    wait_idle("early_idle", n);
    check("early_beats", 32'(beats_sent - b0), 32'd2);
    if (req_log.size() > b0) check("early_req_held", 32'(req_log[b0]), 32'h1);
    check("early_word", sdram_rdata, 32'hDEADBEEF);

    // Randomized mix against the word-level reference.
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      ra = 24'(32 + $urandom_range(0, 7));
      ack_lat = $urandom_range(0, 3);
      rd_lat = $urandom_range(1, 5);
      issue(op < 2, op >= 2, ra, $urandom, 0);
      if ($urandom_range(0, 1) == 1) begin
        sdram_rd = 1'($urandom_range(0, 1));
        sdram_wr = ~sdram_rd;
        sdram_addr = 24'(32 + $urandom_range(0, 7));
        sdram_wdata = $urandom;
        @(negedge clk);
        sdram_rd = 1'b0; sdram_wr = 1'b0;
      end
      wait_idle("rand_idle", n);
      check("rand_done", 32'(exp_q.size()), 32'h0);
      check("rand_rdata_hold", sdram_rdata, last_rd);
    end

    // Final sweep: read back every touched word.
    ack_lat = 1;
    rd_lat = 3;
    for (int a = 32; a < 40; a++) begin
      issue(1'b1, 1'b0, 24'(a), 32'h0, 0);
      wait_idle("sweep_idle", n);
      rd_w = ref_rd(24'(a));
      check("sweep_word", sdram_rdata, rd_w);
    end

    repeat (4) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
